// File: rtl/mult_pkg.sv
// Shared types and constants for the signed shift-add multiplier control path.
package mult_pkg;

    localparam int unsigned MULT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } mult_state_t;

endpackage : mult_pkg

// File: rtl/multiplier_control.sv
// Sequencing FSM for the signed shift-add multiplier: one conditional
// add/sub plus one arithmetic shift per multiplier bit, subtract on the last.
module multiplier_control
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Clr_XA,
    output logic Ld_XA,
    output logic Ld_B,
    output logic Shift_En,
    output logic Add,
    output logic Sub,
    output logic Done
);

    localparam int unsigned      CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    mult_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and iteration counter; reset abandons any product in flight.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter update and strobe decode (decoded straight from state).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        Clr_XA   = 1'b0;
        Ld_XA    = 1'b0;
        Ld_B     = 1'b0;
        Shift_En = 1'b0;
        Add      = 1'b0;
        Sub      = 1'b0;
        Done     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (Run) begin
                    state_d = CLR;
                end else if (ClearA_LoadB) begin
                    // Load strobes stay quiet while reset is held.
                    Clr_XA = Reset_n;
                    Ld_B   = Reset_n;
                end
            end
            CLR: begin
                Clr_XA  = 1'b1;
                cnt_d   = '0;
                state_d = ADD;
            end
            ADD: begin
                if (M) begin
                    Ld_XA = 1'b1;
                    if (cnt_q == LAST) begin
                        Sub = 1'b1;
                    end else begin
                        Add = 1'b1;
                    end
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                Shift_En = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ADD;
                end
            end
            DONE: begin
                Done = 1'b1;
                if (!Run) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule : multiplier_control

// File: tb/tb_multiplier_control.sv
// Bench for multiplier_control: drives a behavioural register unit/adder from
// the DUT strobes and scoreboards each product against signed arithmetic.
module tb_multiplier_control;

    localparam int unsigned W   = 8;
    localparam int unsigned LAT = 2 * W + 1;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic Run = 1'b0;
    logic ClearA_LoadB = 1'b0;
    logic M;
    logic Clr_XA, Ld_XA, Ld_B, Shift_En, Add, Sub, Done;

    // Switch data and behavioural register unit X:A:B
    logic [7:0] sw  = 8'h00;
    logic       x_r = 1'b0;
    logic [7:0] a_r = 8'h00;
    logic [7:0] b_r = 8'h00;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [15:0] prod;
        int          adds;
        int          subs;
        int          lds;
    } exp_t;

    exp_t exp_q[$];

    multiplier_control #(.WIDTH(W)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .M            (M),
        .Clr_XA       (Clr_XA),
        .Ld_XA        (Ld_XA),
        .Ld_B         (Ld_B),
        .Shift_En     (Shift_En),
        .Add          (Add),
        .Sub          (Sub),
        .Done         (Done)
    );

    always #5 Clk = ~Clk;

    assign M = b_r[0];

    function automatic logic [6:0] outs();
        return {Clr_XA, Ld_XA, Ld_B, Shift_En, Add, Sub, Done};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register unit + 9-bit adder/subtractor reacting to the control strobes
    always @(posedge Clk) begin
        logic [8:0] sum;
        if (Clr_XA) begin
            x_r <= 1'b0;
            a_r <= 8'h00;
        end
        if (Ld_B) b_r <= sw;
        if (Ld_XA) begin
            sum = Sub ? ({a_r[7], a_r} - {sw[7], sw}) : ({a_r[7], a_r} + {sw[7], sw});
            x_r <= sum[8];
            a_r <= sum[7:0];
        end
        if (Shift_En) begin
            a_r <= {x_r, a_r[7:1]};
            b_r <= {a_r[0], b_r[7:1]};
        end
    end

    // Monitor: strobe accounting from each CLR and scoreboard check at Done rise
    int  cyc = 0, n_sh = 0, n_ld = 0, n_add = 0, n_sub = 0, n_ldb = 0;
    logic done_prev = 1'b0;

    always @(negedge Clk) begin
        exp_t e;
        check("add_sub_exclusive", 32'(Add & Sub), 32'd0);
        if (Clr_XA && !Ld_B) begin
            cyc = 0; n_sh = 0; n_ld = 0; n_add = 0; n_sub = 0; n_ldb = 0;
        end else begin
            cyc++;
            n_sh  += int'(Shift_En);
            n_ld  += int'(Ld_XA);
            n_add += int'(Add);
            n_sub += int'(Sub);
            n_ldb += int'(Ld_B);
        end
        if (Done && !done_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("product",   32'({a_r, b_r}), 32'(e.prod));
                check("x_sign",    32'(x_r),        32'(a_r[7]));
                check("latency",   32'(cyc),        32'(LAT));
                check("shift_cnt", 32'(n_sh),       32'(W));
                check("ldxa_cnt",  32'(n_ld),       32'(e.lds));
                check("add_cnt",   32'(n_add),      32'(e.adds));
                check("sub_cnt",   32'(n_sub),      32'(e.subs));
                check("ldb_busy",  32'(n_ldb),      32'd0);
            end
        end
        done_prev = Done;
    end

    // Load B, present multiplicand, run one product and optionally hold Run in DONE
    task automatic run_product(input logic [7:0] b, input logic [7:0] s,
                               input bit hold_clab, input int hold);
        exp_t e;
        bit   seen;
        @(posedge Clk); #1;
        sw = b;
        ClearA_LoadB = 1'b1;
        @(posedge Clk); #1;
        sw = s;
        ClearA_LoadB = hold_clab;
        e.prod = 16'($signed(s) * $signed(b));
        e.adds = 0;
        for (int i = 0; i < int'(W) - 1; i++) e.adds += int'(b[i]);
        e.subs = int'(b[7]);
        e.lds  = e.adds + e.subs;
        exp_q.push_back(e);
        Run = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (Done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_timeout", 32'(seen), 32'd1);
        ClearA_LoadB = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge Clk);
            check("done_hold", 32'(outs()), 32'h01);
        end
        Run = 1'b0;
        @(negedge Clk);
        check("idle_after_done", 32'(outs()), 32'h00);
    endtask

    initial begin
        // Reset held with a load request pending: every output quiet
        ClearA_LoadB = 1'b1;
        sw = 8'h3C;
        @(negedge Clk);
        check("reset_outs", 32'(outs()), 32'h00);
        ClearA_LoadB = 1'b0;
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        @(negedge Clk);
        check("idle_outs", 32'(outs()), 32'h00);

        // Load held two cycles: Clr_XA and Ld_B each cycle, stays in IDLE
        @(posedge Clk); #1;
        ClearA_LoadB = 1'b1;
        @(negedge Clk);
        check("load_cycle0", 32'(outs()), 32'h50);
        @(posedge Clk); #1;
        @(negedge Clk);
        check("load_cycle1", 32'(outs()), 32'h50);
        @(posedge Clk); #1;
        ClearA_LoadB = 1'b0;
        @(negedge Clk);
        check("load_release", 32'(outs()), 32'h00);
        check("b_loaded", 32'(b_r), 32'h3C);

        // Directed products
        run_product(8'h00, 8'h5A, 1'b0, 0);
        run_product(8'hFF, 8'h07, 1'b0, 0);
        run_product(8'h55, 8'h81, 1'b0, 0);
        run_product(8'h80, 8'h80, 1'b0, 0);
        // Run and ClearA_LoadB together: Run wins, Ld_B never during product
        run_product(8'hA7, 8'hF3, 1'b1, 0);
        // Run held in DONE for 40 cycles, then a fresh product
        run_product(8'h13, 8'h7F, 1'b0, 40);
        run_product(8'h01, 8'hFF, 1'b0, 0);

        // Reset during ADD with cnt=3 and M=1
        @(posedge Clk); #1;
        sw = 8'hFF;
        ClearA_LoadB = 1'b1;
        @(posedge Clk); #1;
        ClearA_LoadB = 1'b0;
        sw = 8'h05;
        Run = 1'b1;
        repeat (8) @(posedge Clk);
        @(negedge Clk);
        check("add_cnt3", 32'(outs()), 32'h24);
        Reset_n = 1'b0;
        Run = 1'b0;
        #1;
        check("reset_midop", 32'(outs()), 32'h00);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        @(negedge Clk);
        check("post_reset_idle", 32'(outs()), 32'h00);
        run_product(8'hFF, 8'h07, 1'b0, 0);

        // Random products
        for (int n = 0; n < 20; n++) begin
            run_product(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 0);
        end

        repeat (3) @(negedge Clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_multiplier_control
